// File: rtl/weight_result_collector.sv
// Drain-end collector: captures {valid, result} from the last systolic cell, requantizes to unsigned
// OUTPUT_WIDTH, and streams it out through a FWFT FIFO. Optional rounding via `define RESULT_ROUND_EN.
module weight_result_collector #(
  parameter int RESULT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH  = 8,
  parameter int CELL_AMOUNT   = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int SHIFT         = 8,
  parameter int OUTPUT_OFFSET = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [RESULT_WIDTH:0]         input_result,
  output logic [OUTPUT_WIDTH-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clear
);

  localparam int XW = RESULT_WIDTH + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (CELL_AMOUNT > 1) ? $clog2(CELL_AMOUNT) : 1;
  localparam int EW = OUTPUT_WIDTH + 1;

  localparam logic [GW-1:0]        GRP_LAST = GW'(CELL_AMOUNT - 1);
  localparam logic [CW-1:0]        FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic signed [XW-1:0] OFFSET_X = XW'(OUTPUT_OFFSET);
  localparam logic signed [XW-1:0] MAX_X    = XW'((2 ** OUTPUT_WIDTH) - 1);
`ifdef RESULT_ROUND_EN
  localparam int                   RSH       = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [XW-1:0] ROUND_ADD = (SHIFT > 0) ? XW'(1) << RSH : '0;
`endif

  // Capture stage
  logic                    cap_valid_q, cap_valid_d;
  logic [RESULT_WIDTH-1:0] cap_result_q, cap_result_d;
  logic                    cap_last_q, cap_last_d;
  logic [GW-1:0]           grp_q, grp_d;

  // FIFO state
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic signed [XW-1:0]    ext, rounded, shifted, offs;
  logic [OUTPUT_WIDTH-1:0] sat;
  logic                    pop, full, push, drop;

  always_comb begin
    cap_valid_d  = input_result[RESULT_WIDTH];
    cap_result_d = cap_result_q;
    cap_last_d   = cap_last_q;
    grp_d        = grp_q;
    if (input_result[RESULT_WIDTH]) begin
      cap_result_d = input_result[RESULT_WIDTH-1:0];
      cap_last_d   = (grp_q == GRP_LAST);
      grp_d        = (grp_q == GRP_LAST) ? '0 : grp_q + GW'(1);
    end
  end

  // Two guard bits keep the optional rounding add and the offset add from wrapping.
  always_comb begin
    ext = {{2{cap_result_q[RESULT_WIDTH-1]}}, cap_result_q};
`ifdef RESULT_ROUND_EN
    rounded = ext + ROUND_ADD;
`else
    rounded = ext;
`endif
    shifted = rounded >>> SHIFT;
    offs    = shifted + OFFSET_X;
    if (offs[XW-1]) begin
      sat = '0;
    end else if (offs > MAX_X) begin
      sat = MAX_X[OUTPUT_WIDTH-1:0];
    end else begin
      sat = offs[OUTPUT_WIDTH-1:0];
    end
  end

  // Stream handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready, and out_ready is ignored while out_valid is low.
  always_comb begin
    pop  = (count_q != '0) && out_ready;
    full = (count_q == FULL_CNT);
    push = cap_valid_q && (!full || pop);
    drop = cap_valid_q && full && !pop;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    ovf_d = ovf_q;
    if (overflow_clear) ovf_d = 1'b0;
    if (drop)           ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_valid_q  <= 1'b0;
      cap_result_q <= '0;
      cap_last_q   <= 1'b0;
      grp_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      cap_valid_q  <= cap_valid_d;
      cap_result_q <= cap_result_d;
      cap_last_q   <= cap_last_d;
      grp_q        <= grp_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cap_last_q, sat};
  end

  always_comb begin
    out_valid  = (count_q != '0);
    out_data   = out_valid ? mem_q[rd_ptr_q][OUTPUT_WIDTH-1:0] : '0;
    out_last   = out_valid ? mem_q[rd_ptr_q][OUTPUT_WIDTH] : 1'b0;
    fifo_count = count_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_weight_result_collector.sv
// Self-checking bench for weight_result_collector: vector table, directed corner sequences and a
// randomized phase checked by a scoreboard fed from an arithmetic reference model.
`timescale 1ns/1ps
module tb_weight_result_collector;

  localparam int RW = 16;
  localparam int OW = 8;
  localparam int CA = 4;
  localparam int FD = 8;
  localparam int SH = 8;
  localparam int OFF_B = 200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW:0]   input_result;
  logic          out_ready;
  logic          overflow_clear;
  logic [OW-1:0] out_data;
  logic          out_valid, out_last, overflow;
  logic [$clog2(FD):0] fifo_count;

  logic          b_ready;
  logic [OW-1:0] b_data;
  logic          b_valid, b_last, b_overflow;
  logic [$clog2(FD):0] b_count;

  weight_result_collector #(.RESULT_WIDTH(RW), .OUTPUT_WIDTH(OW), .CELL_AMOUNT(CA),
    .FIFO_DEPTH(FD), .SHIFT(SH), .OUTPUT_OFFSET(0)) dut (
    .clk(clk), .rst_n(rst_n), .input_result(input_result), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .fifo_count(fifo_count), .overflow(overflow), .overflow_clear(overflow_clear));

  weight_result_collector #(.RESULT_WIDTH(RW), .OUTPUT_WIDTH(OW), .CELL_AMOUNT(CA),
    .FIFO_DEPTH(FD), .SHIFT(SH), .OUTPUT_OFFSET(OFF_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .input_result(input_result), .out_data(b_data),
    .out_valid(b_valid), .out_ready(b_ready), .out_last(b_last),
    .fifo_count(b_count), .overflow(b_overflow), .overflow_clear(overflow_clear));

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  int model_idx = 0;
  logic [OW:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference: floor division of the (optionally rounded) result, offset, clamp.
  function automatic logic [OW-1:0] model_q(input logic [RW-1:0] r, input int offset);
    int v, d, q, mx;
    v = int'($signed(r));
`ifdef RESULT_ROUND_EN
    if (SH > 0) v = v + 2 ** (SH - 1);
`endif
    d = 2 ** SH;
    q = (v >= 0) ? v / d : -((-v + d - 1) / d);
    q = q + offset;
    mx = 2 ** OW - 1;
    if (q < 0) q = 0;
    if (q > mx) q = mx;
    return OW'(q);
  endfunction

  // Scoreboard: every accepted beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_pop: got %0h, required no beat (t=%0t)", {out_last, out_data}, $time);
      end else begin
        logic [OW:0] e;
        e = exp_q.pop_front();
        check("sb_pop", 32'({out_last, out_data}), 32'(e));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    input_result = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    model_idx = 0;
  endtask

  task automatic send(input logic [RW-1:0] r, input bit kept);
    input_result = {1'b1, r};
    if (kept) exp_q.push_back({(model_idx == CA - 1), model_q(r, 0)});
    model_idx = (model_idx + 1) % CA;
    tick();
    input_result = '0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    tick();
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_count"}, 32'(fifo_count), 32'd0);
  endtask

  typedef struct {
    logic [RW-1:0] res;
    logic [OW-1:0] a_t, a_r, b_t, b_r;
  } vec_t;
  vec_t vecs[10];

  initial begin
    logic [OW-1:0] ea, eb;
    logic [OW-1:0] got_d[$];
    logic          got_l[$];

    vecs[0] = '{16'h1234, 8'h12, 8'h12, 8'hDA, 8'hDA};
    vecs[1] = '{16'hFF00, 8'h00, 8'h00, 8'hC7, 8'hC7};
    vecs[2] = '{16'h7FFF, 8'h7F, 8'h80, 8'hFF, 8'hFF};
    vecs[3] = '{16'h0180, 8'h01, 8'h02, 8'hC9, 8'hCA};
    vecs[4] = '{16'h8000, 8'h00, 8'h00, 8'h48, 8'h48};
    vecs[5] = '{16'h00FF, 8'h00, 8'h01, 8'hC8, 8'hC9};
    vecs[6] = '{16'hFFFF, 8'h00, 8'h00, 8'hC7, 8'hC8};
    vecs[7] = '{16'h0080, 8'h00, 8'h01, 8'hC8, 8'hC9};
    vecs[8] = '{16'h7F80, 8'h7F, 8'h80, 8'hFF, 8'hFF};
    vecs[9] = '{16'hFF80, 8'h00, 8'h00, 8'hC7, 8'hC8};

    input_result = '0;
    out_ready = 1'b1;
    b_ready = 1'b1;
    overflow_clear = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    do_reset();

    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Vector table: latency, requantization and saturation on both offsets
    for (int i = 0; i < 10; i++) begin
`ifdef RESULT_ROUND_EN
      ea = vecs[i].a_r; eb = vecs[i].b_r;
`else
      ea = vecs[i].a_t; eb = vecs[i].b_t;
`endif
      send(vecs[i].res, 1'b1);
      check("vec_not_early", 32'(out_valid), 32'd0);
      tick();
      check("vec_valid", 32'(out_valid), 32'd1);
      check("vec_data", 32'(out_data), 32'(ea));
      check("vec_b_data", 32'(b_data), 32'(eb));
      tick();
      check("vec_valid_low", 32'(out_valid), 32'd0);
    end

    // Last tagging over two vectors
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(RW'(i << 8), 1'b1);
    tick();
    check("last_count8", 32'(fifo_count), 32'd8);
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      tick();
    end
    check("last_beats", 32'(got_d.size()), 32'd8);
    for (int k = 0; k < 8 && k < got_d.size(); k++) begin
      check("last_data", 32'(got_d[k]), 32'(k + 1));
      check("last_flag", 32'(got_l[k]), 32'((k == 3) || (k == 7)));
    end

    // Overflow under backpressure, then clear
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(RW'($urandom_range(0, 16'hFFFF)), i < FD);
    tick();
    tick();
    check("ovf_count", 32'(fifo_count), 32'(FD));
    check("ovf_set", 32'(overflow), 32'd1);
    drain("ovf_drain");
    check("ovf_sticky", 32'(overflow), 32'd1);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO: push and pop on the same edge
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < FD; i++) send(RW'($urandom_range(0, 16'hFFFF)), 1'b1);
    tick();
    check("full_count", 32'(fifo_count), 32'(FD));
    input_result = {1'b1, 16'h0500};
    exp_q.push_back({(model_idx == CA - 1), model_q(16'h0500, 0)});
    model_idx = (model_idx + 1) % CA;
    tick();
    input_result = '0;
    out_ready = 1'b1;
    tick();
    check("full_pushpop_count", 32'(fifo_count), 32'(FD));
    check("full_pushpop_ovf", 32'(overflow), 32'd0);
    drain("full_drain");

    // Reset mid-stream, then restart the vector index
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(RW'($urandom_range(0, 16'hFFFF)), 1'b1);
    tick();
    check("mid_count5", 32'(fifo_count), 32'd5);
    do_reset();
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(16'h0180, 1'b1);
    tick();
    check("mid_first_data", 32'(out_data), 32'(model_q(16'h0180, 0)));
    check("mid_first_last", 32'(out_last), 32'd0);
    for (int i = 0; i < 3; i++) send(RW'($urandom_range(0, 16'hFFFF)), 1'b1);
    drain("mid_drain");

    // Randomized traffic; issue only while the bench's outstanding count leaves room
    do_reset();
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && exp_q.size() < FD) send(RW'($urandom_range(0, 16'hFFFF)), 1'b1);
      else tick();
    end
    drain("rand_drain");
    check("rand_no_overflow", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
